exec_hazard_ctrl: RTL and testbench
===================================

Name: exec_hazard_ctrl

Overview:
- Sequencing controller for the execute stage of the RV32 pipeline.
- Tracks the destination registers of instructions in the EX, MEM and WB stages, and generates the execute-stage `stall_in`.
- Also generates the ID-to-EX issue/bubble decision, the operand forwarding selects for `rs1`/`rs2`, and a one-cycle flush on taken branches.
- Sequences multi-cycle ALU operations (M-extension) by holding EX for a fixed number of cycles.

Parameters:
- MC_LATENCY, 4, cycles a multi-cycle op occupies EX (legal range 2..15).
- CNT_W, 4, width of the multi-cycle counter; must satisfy 2^CNT_W > MC_LATENCY.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- id_valid  in  1  decode presents a valid instruction for EX.
- id_rs1  in  5  source register 1 index.
- id_rs2  in  5  source register 2 index.
- id_rs1_used  in  1  instruction reads rs1.
- id_rs2_used  in  1  instruction reads rs2.
- id_rd  in  5  destination register index.
- id_rd_we  in  1  instruction writes rd.
- id_is_load  in  1  opcode 0000011.
- id_multicycle  in  1  opcode 0110011 with funct7 0000001.
- ex_branch_taken  in  1  branch/jump resolved taken in EX (valid only while `ex_valid_out`=1).
- stall_out  out  1  drives execute `stall_in`; also holds IF/ID.
- flush_out  out  1  kill IF/ID contents this cycle.
- issue_out  out  1  ID instruction moves into EX at this edge (combinational).
- ex_valid_out  out  1  EX holds a real (non-bubble) instruction.
- fwd_rs1_sel  out  2  00 regfile, 01 MEM-stage result, 10 WB-stage result; registered at issue.
- fwd_rs2_sel  out  2  same encoding, for rs2.
- mc_busy_out  out  1  multi-cycle op in progress.

Behaviour:
- State is three stage records, EX/MEM/WB, each holding {valid, rd, rd_we, is_load}, plus a multi-cycle down-counter `mc_cnt`.
- Reset:
  - All records invalid; `mc_cnt`=0.
  - All outputs 0, `fwd_*_sel`=00.
  - Reset mid multi-cycle op aborts it with no further stall.
- Hazard terms (combinational):
  - `lu_haz` = EX valid & EX is_load & EX rd_we & EX rd≠0 & id_valid & ((id_rs1_used & id_rs1==EX rd) | (id_rs2_used & id_rs2==EX rd)).
  - `mc_haz` = (`mc_cnt`≠0).
- Output equations:
  - `flush_out` = ex_branch_taken & ex_valid_out.
  - `stall_out` = (`lu_haz` | `mc_haz`) & !`flush_out`.
  - `issue_out` = id_valid & !`stall_out` & !`flush_out`.
- Priority: flush > multi-cycle stall > load-use stall > issue.
  - A taken branch is never multi-cycle; if both occur, flush wins and `mc_cnt` clears.
- Each rising edge, when not stalled:
  - WB ← MEM, MEM ← EX.
  - EX ← ID record if `issue_out`, else bubble (valid=0).
- Each rising edge, when stalled:
  - Multi-cycle stall: EX, MEM and WB hold.
  - Load-use stall: EX advances to MEM and a bubble enters EX. This is exactly a 1-cycle stall.
- Multi-cycle sequencing:
  - On issue of an instruction with `id_multicycle`=1, load `mc_cnt`=MC_LATENCY-1.
  - Decrement while nonzero.
  - EX therefore holds that instruction MC_LATENCY cycles total.
  - `mc_busy_out` = (`mc_cnt`≠0).
- Forwarding, evaluated on the ID operands at issue and registered into `fwd_*_sel`:
  - If the register is used, its index ≠0, and it matches the EX record (valid, rd_we, !is_load): select 01.
  - Else if it matches the MEM record (valid, rd_we): select 10.
  - Else select 00.
  - The newest producer wins.
  - x0 is never forwarded.
  - The selects hold while EX holds, and reset to 00 when a bubble enters EX.
- `ex_valid_out` = EX record valid.
- Back-to-back multi-cycle ops: the second issues on the cycle `mc_cnt` reaches 0.
- Load followed by a multi-cycle consumer: 1 load-use stall, then the multi-cycle sequence.

Test Plan:
- Reset held 2 cycles with id_valid=1 → all outputs 0 and `fwd_*_sel`=00; the first instruction issues on the cycle after reset deasserts.
- ADD x5 then SUB using x5 as rs1, back-to-back → no stall; `fwd_rs1_sel`=01 during SUB in EX. Insert one NOP between them → `fwd_rs1_sel`=10.
- LW x7 then ADD using x7 as rs2 → `stall_out`=1 for exactly 1 cycle and a bubble enters EX; ADD issues next with `fwd_rs2_sel`=10.
- MUL (multi-cycle) with MC_LATENCY=4 → `stall_out` high 3 cycles, `mc_busy_out` high 3 cycles; the next instruction issues in cycle 4. Repeat with ADDI writing x0 followed by a reader of x0 → `fwd_rs1_sel`=00.
- Taken BEQ in EX with LW/consumer hazard pending in ID → `flush_out`=1 for 1 cycle, `stall_out`=0, a bubble enters EX, and `ex_valid_out`=0 the next cycle.
- Assert reset during cycle 2 of a MUL → the next cycle has `mc_busy_out`=0, `stall_out`=0, and all records invalid.

Source files
------------

// File: rtl/exec_hazard_ctrl.sv
// exec_hazard_ctrl: execute-stage sequencing controller for the RV32 pipeline.
//
// Tracks the destination registers of the instructions in EX, MEM and WB and,
// from them, decides each cycle whether the decoded instruction issues into EX,
// whether EX stalls (load-use or multi-cycle ALU op), whether IF/ID is flushed
// on a taken branch, and which bypass source each EX operand uses.
//
// Ports:
//   clk, reset       rising-edge clock, synchronous active-high reset
//   id_*             decoded instruction presented to EX (valid, sources,
//                    destination, load / multi-cycle class)
//   ex_branch_taken  branch/jump in EX resolved taken (ignored if EX is a bubble)
//   stall_out        execute stall_in; also holds IF/ID
//   flush_out        kill IF/ID contents this cycle
//   issue_out        ID instruction enters EX at this edge (combinational)
//   ex_valid_out     EX holds a real instruction
//   fwd_rs1_sel      EX operand source: 00 regfile, 01 MEM result, 10 WB result
//   fwd_rs2_sel      same encoding for rs2
//   mc_busy_out      multi-cycle op still occupying EX
module exec_hazard_ctrl #(
  parameter int unsigned MC_LATENCY = 4,  // cycles a multi-cycle op stays in EX (2..15)
  parameter int unsigned CNT_W      = 4   // must satisfy 2**CNT_W > MC_LATENCY
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_rs1_used,
  input  logic       id_rs2_used,
  input  logic [4:0] id_rd,
  input  logic       id_rd_we,
  input  logic       id_is_load,
  input  logic       id_multicycle,
  input  logic       ex_branch_taken,
  output logic       stall_out,
  output logic       flush_out,
  output logic       issue_out,
  output logic       ex_valid_out,
  output logic [1:0] fwd_rs1_sel,
  output logic [1:0] fwd_rs2_sel,
  output logic       mc_busy_out
);

  localparam int unsigned REG_W = 5;
  localparam int unsigned SEL_W = 2;

  localparam logic [SEL_W-1:0] FWD_RF  = 2'b00;
  localparam logic [SEL_W-1:0] FWD_MEM = 2'b01;
  localparam logic [SEL_W-1:0] FWD_WB  = 2'b10;

  // Per-stage bookkeeping of the instruction occupying that stage.
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             rd_we;
    logic             is_load;
  } stage_rec_t;

  stage_rec_t       ex_q, ex_d;
  stage_rec_t       mem_q, mem_d;
  stage_rec_t       wb_q, wb_d;
  stage_rec_t       id_rec;
  logic [CNT_W-1:0] mc_cnt_q, mc_cnt_d;
  logic [SEL_W-1:0] fwd_rs1_q, fwd_rs1_d;
  logic [SEL_W-1:0] fwd_rs2_q, fwd_rs2_d;

  logic lu_haz;
  logic mc_haz;
  logic flush;
  logic stall;
  logic issue;
  logic rs1_lu;
  logic rs2_lu;

  // Bypass source for one ID operand. A load in EX cannot forward (its data
  // arrives a stage late), which the load-use stall covers; EX is checked first
  // so the newest producer wins. x0 is never forwarded.
  function automatic logic [SEL_W-1:0] fwd_pick(
    input logic             used,
    input logic [REG_W-1:0] rs,
    input stage_rec_t       ex_rec,
    input logic             mem_wr,
    input logic [REG_W-1:0] mem_rd
  );
    logic [SEL_W-1:0] sel;
    sel = FWD_RF;
    if (used && (rs != '0)) begin
      if (ex_rec.valid && ex_rec.rd_we && !ex_rec.is_load && (ex_rec.rd == rs)) begin
        sel = FWD_MEM;
      end else if (mem_wr && (mem_rd == rs)) begin
        sel = FWD_WB;
      end
    end
    return sel;
  endfunction

  // Record entering EX when the decoded instruction issues.
  assign id_rec = '{valid: 1'b1, rd: id_rd, rd_we: id_rd_we, is_load: id_is_load};

  // Hazard detection.
  assign rs1_lu = id_rs1_used && (id_rs1 == ex_q.rd);
  assign rs2_lu = id_rs2_used && (id_rs2 == ex_q.rd);
  assign lu_haz = ex_q.valid && ex_q.is_load && ex_q.rd_we && (ex_q.rd != '0) &&
                  id_valid && (rs1_lu || rs2_lu);
  assign mc_haz = (mc_cnt_q != '0);

  // Priority: flush > multi-cycle stall > load-use stall > issue.
  assign flush = ex_branch_taken && ex_q.valid;
  assign stall = (lu_haz || mc_haz) && !flush;
  assign issue = id_valid && !stall && !flush;

  // Next-state for the stage records, multi-cycle counter and operand selects.
  always_comb begin
    ex_d      = ex_q;
    mem_d     = mem_q;
    wb_d      = wb_q;
    mc_cnt_d  = mc_cnt_q;
    fwd_rs1_d = fwd_rs1_q;
    fwd_rs2_d = fwd_rs2_q;

    if (mc_haz && !flush) begin
      // Multi-cycle op holds the whole back end while the counter drains.
      mc_cnt_d = mc_cnt_q - CNT_W'(1);
    end else begin
      // Pipeline advances; a bubble enters EX unless the ID instruction issues.
      // This path also covers the load-use stall and the flush, and a flush
      // aborts any multi-cycle count.
      wb_d      = mem_q;
      mem_d     = ex_q;
      ex_d      = '0;
      fwd_rs1_d = FWD_RF;
      fwd_rs2_d = FWD_RF;
      mc_cnt_d  = '0;
      if (issue) begin
        ex_d      = id_rec;
        fwd_rs1_d = fwd_pick(id_rs1_used, id_rs1, ex_q, mem_q.valid && mem_q.rd_we, mem_q.rd);
        fwd_rs2_d = fwd_pick(id_rs2_used, id_rs2, ex_q, mem_q.valid && mem_q.rd_we, mem_q.rd);
        if (id_multicycle) begin
          mc_cnt_d = CNT_W'(MC_LATENCY - 1);
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      mc_cnt_q  <= '0;
      fwd_rs1_q <= FWD_RF;
      fwd_rs2_q <= FWD_RF;
    end else begin
      ex_q      <= ex_d;
      mem_q     <= mem_d;
      wb_q      <= wb_d;
      mc_cnt_q  <= mc_cnt_d;
      fwd_rs1_q <= fwd_rs1_d;
      fwd_rs2_q <= fwd_rs2_d;
    end
  end

  // Combinational controls are forced low while reset is asserted so that
  // nothing issues or stalls before the records are known to be clean.
  assign flush_out    = flush && !reset;
  assign stall_out    = stall && !reset;
  assign issue_out    = issue && !reset;
  assign ex_valid_out = ex_q.valid;
  assign fwd_rs1_sel  = fwd_rs1_q;
  assign fwd_rs2_sel  = fwd_rs2_q;
  assign mc_busy_out  = mc_haz;

  // WB record and MEM load flag are tracked for pipeline visibility only;
  // the bypass network does not consult them.
  logic unused_rec;
  assign unused_rec = ^{mem_q.is_load, wb_q};

endmodule

// File: tb/tb_exec_hazard_ctrl.sv
module tb_exec_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_rs1_used;
  logic       id_rs2_used;
  logic [4:0] id_rd;
  logic       id_rd_we;
  logic       id_is_load;
  logic       id_multicycle;
  logic       ex_branch_taken;
  logic       stall_out;
  logic       flush_out;
  logic       issue_out;
  logic       ex_valid_out;
  logic [1:0] fwd_rs1_sel;
  logic [1:0] fwd_rs2_sel;
  logic       mc_busy_out;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  exec_hazard_ctrl #(.MC_LATENCY(4), .CNT_W(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .id_valid       (id_valid),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_rs1_used    (id_rs1_used),
    .id_rs2_used    (id_rs2_used),
    .id_rd          (id_rd),
    .id_rd_we       (id_rd_we),
    .id_is_load     (id_is_load),
    .id_multicycle  (id_multicycle),
    .ex_branch_taken(ex_branch_taken),
    .stall_out      (stall_out),
    .flush_out      (flush_out),
    .issue_out      (issue_out),
    .ex_valid_out   (ex_valid_out),
    .fwd_rs1_sel    (fwd_rs1_sel),
    .fwd_rs2_sel    (fwd_rs2_sel),
    .mc_busy_out    (mc_busy_out)
  );

  typedef struct {
    logic       v;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       we;
    logic       ld;
    logic       mc;
    logic       br;
    logic       e_st;
    logic       e_fl;
    logic       e_is;
    logic       e_ev;
    logic [1:0] e_f1;
    logic [1:0] e_f2;
    logic       e_bz;
  } vec_t;

  typedef struct {
    logic       st;
    logic       fl;
    logic       is;
    logic       ev;
    logic [1:0] f1;
    logic [1:0] f2;
    logic       bz;
  } exp_t;

  localparam int NVEC = 26;
  vec_t tbl [NVEC];
  exp_t sb [$];

  function automatic vec_t mk(input int v, rs1, u1, rs2, u2, rd, we, ld, mc, br,
                              input int st, fl, is_, ev, f1, f2, bz);
    vec_t r;
    r.v = 1'(v);   r.rs1 = 5'(rs1); r.u1 = 1'(u1); r.rs2 = 5'(rs2); r.u2 = 1'(u2);
    r.rd = 5'(rd); r.we = 1'(we);   r.ld = 1'(ld); r.mc = 1'(mc);   r.br = 1'(br);
    r.e_st = 1'(st); r.e_fl = 1'(fl); r.e_is = 1'(is_); r.e_ev = 1'(ev);
    r.e_f1 = 2'(f1); r.e_f2 = 2'(f2); r.e_bz = 1'(bz);
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input int v, rs1, u1, rs2, u2, rd, we, ld, mc, br);
    id_valid = 1'(v);  id_rs1 = 5'(rs1); id_rs1_used = 1'(u1);
    id_rs2 = 5'(rs2);  id_rs2_used = 1'(u2);
    id_rd = 5'(rd);    id_rd_we = 1'(we); id_is_load = 1'(ld);
    id_multicycle = 1'(mc); ex_branch_taken = 1'(br);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int   n_st;
    int   n_bz;
    logic done;

    //      v rs1 u1 rs2 u2 rd we ld mc br | st fl is ev f1 f2 bz
    tbl[0]  = mk(1,  1, 1,  2, 1,  5, 1, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0); // ADD x5
    tbl[1]  = mk(1,  5, 1,  3, 1,  6, 1, 0, 0, 0,  0, 0, 1, 1, 0, 0, 0); // SUB x6 <- x5
    tbl[2]  = mk(0,  0, 0,  0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 1, 1, 0, 0); // NOP, SUB sel 01
    tbl[3]  = mk(1,  6, 1,  4, 1,  9, 1, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0); // AND x9 <- x6
    tbl[4]  = mk(1, 10, 1,  0, 0,  7, 1, 1, 0, 0,  0, 0, 1, 1, 2, 0, 0); // LW x7, AND sel 10
    tbl[5]  = mk(1, 12, 1,  7, 1, 11, 1, 0, 0, 0,  1, 0, 0, 1, 0, 0, 0); // ADD <- x7: stall
    tbl[6]  = mk(1, 12, 1,  7, 1, 11, 1, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0); // bubble in EX
    tbl[7]  = mk(1, 11, 1, 11, 1, 13, 1, 0, 1, 0,  0, 0, 1, 1, 0, 2, 0); // MUL x13
    tbl[8]  = mk(1,  1, 1,  2, 1, 14, 1, 0, 0, 0,  1, 0, 0, 1, 1, 1, 1); // XOR held
    tbl[9]  = mk(1,  1, 1,  2, 1, 14, 1, 0, 0, 0,  1, 0, 0, 1, 1, 1, 1);
    tbl[10] = mk(1,  1, 1,  2, 1, 14, 1, 0, 0, 0,  1, 0, 0, 1, 1, 1, 1);
    tbl[11] = mk(1,  1, 1,  2, 1, 14, 1, 0, 0, 0,  0, 0, 1, 1, 1, 1, 0); // XOR issues
    tbl[12] = mk(1,  1, 1,  0, 0,  0, 1, 0, 0, 0,  0, 0, 1, 1, 0, 0, 0); // ADDI x0
    tbl[13] = mk(1,  0, 1,  3, 1, 15, 1, 0, 0, 0,  0, 0, 1, 1, 0, 0, 0); // ADD <- x0
    tbl[14] = mk(0,  0, 0,  0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0); // x0 not forwarded
    tbl[15] = mk(1,  1, 1,  2, 1,  0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0); // BEQ
    tbl[16] = mk(1,  1, 1,  0, 0, 20, 1, 1, 0, 1,  0, 1, 0, 1, 0, 0, 0); // taken: flush
    tbl[17] = mk(1, 20, 1,  1, 1, 21, 1, 0, 0, 1,  0, 0, 1, 0, 0, 0, 0); // stale taken ignored
    tbl[18] = mk(1,  1, 1,  0, 0, 22, 1, 1, 0, 0,  0, 0, 1, 1, 0, 0, 0); // LW x22
    tbl[19] = mk(1, 22, 1,  2, 1, 23, 1, 0, 1, 0,  1, 0, 0, 1, 0, 0, 0); // MUL <- x22: lu stall
    tbl[20] = mk(1, 22, 1,  2, 1, 23, 1, 0, 1, 0,  0, 0, 1, 0, 0, 0, 0); // MUL issues
    tbl[21] = mk(0,  0, 0,  0, 0,  0, 0, 0, 0, 0,  1, 0, 0, 1, 2, 0, 1);
    tbl[22] = mk(1, 23, 1, 23, 1, 24, 1, 0, 1, 0,  1, 0, 0, 1, 2, 0, 1); // 2nd MUL waits
    tbl[23] = mk(1, 23, 1, 23, 1, 24, 1, 0, 1, 0,  1, 0, 0, 1, 2, 0, 1);
    tbl[24] = mk(1, 23, 1, 23, 1, 24, 1, 0, 1, 0,  0, 0, 1, 1, 2, 0, 0); // issues at cnt 0
    tbl[25] = mk(0,  0, 0,  0, 0,  0, 0, 0, 0, 0,  1, 0, 0, 1, 1, 1, 1);

    // Reset held two edges with a valid instruction presented.
    reset = 1'b1;
    drive(1, 1, 1, 2, 1, 5, 1, 0, 0, 0);
    next_cycle();
    @(negedge clk);
    chk("rst_stall", int'(stall_out), 0);
    chk("rst_flush", int'(flush_out), 0);
    chk("rst_issue", int'(issue_out), 0);
    chk("rst_exv",   int'(ex_valid_out), 0);
    chk("rst_fwd1",  int'(fwd_rs1_sel), 0);
    chk("rst_fwd2",  int'(fwd_rs2_sel), 0);
    chk("rst_busy",  int'(mc_busy_out), 0);
    next_cycle();
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      drive(int'(tbl[i].v), int'(tbl[i].rs1), int'(tbl[i].u1), int'(tbl[i].rs2),
            int'(tbl[i].u2), int'(tbl[i].rd), int'(tbl[i].we), int'(tbl[i].ld),
            int'(tbl[i].mc), int'(tbl[i].br));
      sb.push_back('{st: tbl[i].e_st, fl: tbl[i].e_fl, is: tbl[i].e_is, ev: tbl[i].e_ev,
                     f1: tbl[i].e_f1, f2: tbl[i].e_f2, bz: tbl[i].e_bz});
      @(negedge clk);
      e = sb.pop_front();
      chk($sformatf("c%0d_stall", i), int'(stall_out),    int'(e.st));
      chk($sformatf("c%0d_flush", i), int'(flush_out),    int'(e.fl));
      chk($sformatf("c%0d_issue", i), int'(issue_out),    int'(e.is));
      chk($sformatf("c%0d_exv",   i), int'(ex_valid_out), int'(e.ev));
      chk($sformatf("c%0d_fwd1",  i), int'(fwd_rs1_sel),  int'(e.f1));
      chk($sformatf("c%0d_fwd2",  i), int'(fwd_rs2_sel),  int'(e.f2));
      chk($sformatf("c%0d_busy",  i), int'(mc_busy_out),  int'(e.bz));
      next_cycle();
    end

    // Reset in the second cycle of the MUL now in EX aborts it.
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    next_cycle();
    reset = 1'b0;
    drive(1, 24, 1, 13, 1, 26, 1, 0, 0, 0);
    @(negedge clk);
    chk("abort_busy",  int'(mc_busy_out), 0);
    chk("abort_stall", int'(stall_out), 0);
    chk("abort_flush", int'(flush_out), 0);
    chk("abort_exv",   int'(ex_valid_out), 0);
    chk("abort_issue", int'(issue_out), 1);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("abort_exv2", int'(ex_valid_out), 1);
    chk("abort_fwd1", int'(fwd_rs1_sel), 0);
    chk("abort_fwd2", int'(fwd_rs2_sel), 0);
    next_cycle();

    // Fresh MUL: count the stall and busy cycles before a dependent ADD issues.
    drive(1, 1, 1, 2, 1, 25, 1, 0, 1, 0);
    @(negedge clk);
    chk("mul_issue", int'(issue_out), 1);
    next_cycle();
    drive(1, 25, 1, 3, 1, 27, 1, 0, 0, 0);
    n_st = 0;
    n_bz = 0;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (mc_busy_out) n_bz++;
      if (stall_out) begin
        n_st++;
        next_cycle();
      end else begin
        done = 1'b1;
      end
    end
    chk("mul_done",   int'(done), 1);
    chk("mul_stalls", n_st, 3);
    chk("mul_busy",   n_bz, 3);
    chk("mul_next_issue", int'(issue_out), 1);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("mul_dep_exv",  int'(ex_valid_out), 1);
    chk("mul_dep_fwd1", int'(fwd_rs1_sel), 1);
    chk("mul_dep_fwd2", int'(fwd_rs2_sel), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
